// File: rtl/rv32_fetch_pkg.sv
// rtl/rv32_fetch_pkg.sv - shared types and constants for the RV32I instruction fetch unit
package rv32_fetch_pkg;

  localparam int ILEN     = 32;
  localparam int OPCODE_W = 7;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter register with +4 advance, redirect mux and alignment check
module fetch_pc_gen #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic            advance,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign misalign = redirect_en && (branch_target[1:0] != 2'b00);
  assign pc       = pc_q;

  // A misaligned target leaves the PC untouched; the wrap past the top of memory is intentional.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      if (!misalign) pc_d = branch_target;
    end else if (advance) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - one-outstanding instruction fetch with redirect, discard and sticky misalign fault
module instr_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [ILEN-1:0]     imem_rsp_data,
  input  logic                stall,
  input  logic                pc_src,
  input  logic [XLEN-1:0]     branch_target,
  output logic [ILEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic                instr_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic                misalign_fault
);

  fetch_state_t    state_q, state_d;
  logic            discard_q, discard_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fault_q, fault_d;
  logic            capture;
  logic            redirect_en;
  logic            misalign;
  logic [XLEN-1:0] pc;

  assign redirect_en = pc_src && (state_q != S_FAULT);

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC[XLEN-1:0])
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_en   (redirect_en),
    .branch_target (branch_target),
    .advance       (capture),
    .pc            (pc),
    .misalign      (misalign)
  );

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    capture       = 1'b0;
    if (redirect_en && misalign) begin
      fault_d       = 1'b1;
      instr_valid_d = 1'b0;
      state_d       = S_FAULT;
    end else if (redirect_en) begin
      // A redirect kills whatever is in flight; an accepted request must have its response dropped.
      instr_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: ;
      endcase
    end else begin
      case (state_q)
        S_REQ: if (imem_req_ready) state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else begin
              instr_d       = imem_rsp_data;
              instr_pc_d    = pc;
              instr_valid_d = 1'b1;
              capture       = 1'b1;
              state_d       = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_valid_d = 1'b0;
            state_d       = S_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      discard_q     <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = instr_valid_q;
  assign opcode         = instr_q[OPCODE_W-1:0];
  assign misalign_fault = fault_q;

endmodule
